// File: rtl/button_input.sv
// Stopwatch input front end: two-flop synchronizer and debouncer per raw input,
// press pulses for the two buttons, and the run/pause state register.
module button_input #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_pause,
  input  logic btn_rst,
  input  logic sw_adj,
  input  logic sw_sel,
  output logic paused,
  output logic clear,
  output logic pause_pulse,
  output logic adj,
  output logic sel
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Channel order: 0 = btn_pause, 1 = btn_rst, 2 = sw_adj, 3 = sw_sel.
  logic [3:0] raw;
  logic [1:0] rise;
  logic [1:0] level;

  assign raw = {sw_sel, sw_adj, btn_rst, btn_pause};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_ch
      logic             s1_q;
      logic             s2_q;
      logic             stable_q;
      logic             stable_d;
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;

      // Any cycle where s2 agrees with the stable value restarts the count.
      always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (s2_q != stable_q) begin
          if (cnt_q == CNT_MAX) begin
            stable_d = s2_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s1_q     <= 1'b0;
          s2_q     <= 1'b0;
          stable_q <= 1'b0;
          cnt_q    <= '0;
        end else begin
          s1_q     <= raw[gi];
          s2_q     <= s1_q;
          stable_q <= stable_d;
          cnt_q    <= cnt_d;
        end
      end

      if (gi < 2) begin : g_btn
        assign rise[gi] = ~stable_q & stable_d;
      end else begin : g_sw
        assign level[gi-2] = stable_q;
      end
    end
  endgenerate

  logic paused_q;
  logic paused_d;
  logic clear_q;
  logic clear_d;
  logic pause_pulse_q;
  logic pause_pulse_d;

  // Pulses register in the same edge the stable value rises; clear beats toggle.
  always_comb begin
    clear_d       = rise[1];
    pause_pulse_d = rise[0];
    paused_d      = paused_q;
    if (rise[1]) begin
      paused_d = 1'b0;
    end else if (rise[0]) begin
      paused_d = ~paused_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      paused_q      <= 1'b0;
      clear_q       <= 1'b0;
      pause_pulse_q <= 1'b0;
    end else begin
      paused_q      <= paused_d;
      clear_q       <= clear_d;
      pause_pulse_q <= pause_pulse_d;
    end
  end

  assign paused      = paused_q;
  assign clear       = clear_q;
  assign pause_pulse = pause_pulse_q;
  assign adj         = level[0];
  assign sel         = level[1];

endmodule

// File: tb/tb_button_input.sv
// Bench for button_input: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a behavioural model.
module tb_button_input;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_pause = 1'b0;
  logic btn_rst = 1'b0;
  logic sw_adj = 1'b0;
  logic sw_sel = 1'b0;
  logic paused, clear, pause_pulse, adj, sel;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  button_input #(.DEBOUNCE_CYCLES(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_pause(btn_pause), .btn_rst(btn_rst), .sw_adj(sw_adj), .sw_sel(sw_sel),
    .paused(paused), .clear(clear), .pause_pulse(pause_pulse), .adj(adj), .sel(sel)
  );

  always #5 clk = ~clk;

  // Behavioural model: raw value reaches the debouncer two edges late; the
  // stable value follows it after N consecutive disagreeing samples.
  logic [3:0] m_s1 = '0, m_s2 = '0, m_stable = '0, m_raw;
  int         m_run [4] = '{0, 0, 0, 0};
  logic       m_clear = 1'b0, m_pp = 1'b0, m_paused = 1'b0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_stable = '0;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
      m_clear = 1'b0; m_pp = 1'b0; m_paused = 1'b0;
    end else begin
      m_raw = {sw_sel, sw_adj, btn_rst, btn_pause};
      m_clear = 1'b0;
      m_pp = 1'b0;
      for (int i = 0; i < 4; i++) begin
        m_run[i] = (m_s2[i] != m_stable[i]) ? m_run[i] + 1 : 0;
        if (m_run[i] == N) begin
          m_stable[i] = m_s2[i];
          m_run[i] = 0;
          if (m_stable[i] && i == 0) m_pp = 1'b1;
          if (m_stable[i] && i == 1) m_clear = 1'b1;
        end
      end
      m_s2 = m_s1;
      m_s1 = m_raw;
      if (m_clear) m_paused = 1'b0;
      else if (m_pp) m_paused = ~m_paused;
    end
  end

  task automatic chk(input string name, input logic got, input logic exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b at %0t", name, got, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("model.paused", paused, m_paused);
      chk("model.clear", clear, m_clear);
      chk("model.pause_pulse", pause_pulse, m_pp);
      chk("model.adj", adj, m_stable[2]);
      chk("model.sel", sel, m_stable[3]);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic settle();
    btn_pause = 1'b0; btn_rst = 1'b0; sw_adj = 1'b0; sw_sel = 1'b0;
    step(12);
  endtask

  initial begin
    // 1. Reset with all inputs high, then release.
    btn_pause = 1'b1; btn_rst = 1'b1; sw_adj = 1'b1; sw_sel = 1'b1;
    step(3);
    chk_en = 1'b1;
    step(1);
    chk("rst.adj", adj, 1'b0);
    chk("rst.clear", clear, 1'b0);
    chk("rst.paused", paused, 1'b0);
    rst_n = 1'b1;
    step(5);
    chk("rel.e5.adj", adj, 1'b0);
    chk("rel.e5.pp", pause_pulse, 1'b0);
    step(1);
    chk("rel.e6.adj", adj, 1'b1);
    chk("rel.e6.sel", sel, 1'b1);
    chk("rel.e6.clear", clear, 1'b1);
    chk("rel.e6.pp", pause_pulse, 1'b1);
    chk("rel.e6.paused", paused, 1'b0);
    step(1);
    chk("rel.e7.clear", clear, 1'b0);
    chk("rel.e7.pp", pause_pulse, 1'b0);
    $display("[TB] reset/release done");
    settle();

    // 2. Clean press, then a second press.
    btn_pause = 1'b1;
    step(5);
    chk("press.e5.pp", pause_pulse, 1'b0);
    step(1);
    chk("press.e6.pp", pause_pulse, 1'b1);
    chk("press.e6.paused", paused, 1'b1);
    step(1);
    chk("press.e7.pp", pause_pulse, 1'b0);
    chk("press.e7.paused", paused, 1'b1);
    btn_pause = 1'b0;
    step(10);
    btn_pause = 1'b1;
    step(6);
    chk("press2.paused", paused, 1'b0);
    $display("[TB] clean press done");
    settle();

    // 3. Bounce: short high segments never register.
    for (int k = 0; k < 2; k++) begin
      btn_pause = 1'b1; step(1); chk("bounce.pp", pause_pulse, 1'b0);
      step(1); chk("bounce.pp", pause_pulse, 1'b0);
      btn_pause = 1'b0; step(1); chk("bounce.pp", pause_pulse, 1'b0);
    end
    btn_pause = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step(1);
      chk("bounce.hold.pp", pause_pulse, 1'b0);
    end
    step(1);
    chk("bounce.e6.pp", pause_pulse, 1'b1);
    chk("bounce.e6.paused", paused, 1'b1);
    $display("[TB] bounce done");
    settle();

    // 4. Simultaneous press while paused: clear wins.
    btn_pause = 1'b1; btn_rst = 1'b1;
    step(6);
    chk("simul.clear", clear, 1'b1);
    chk("simul.pp", pause_pulse, 1'b1);
    chk("simul.paused", paused, 1'b0);
    $display("[TB] simultaneous press done");
    settle();

    // 5. Switch level follows with the same latency both ways.
    sw_adj = 1'b1;
    step(5); chk("sw.e5.adj", adj, 1'b0);
    step(1); chk("sw.e6.adj", adj, 1'b1);
    step(4);
    sw_adj = 1'b0;
    step(5); chk("sw.fall.e5.adj", adj, 1'b1);
    step(1); chk("sw.fall.e6.adj", adj, 1'b0);
    chk("sw.clear", clear, 1'b0);
    chk("sw.pp", pause_pulse, 1'b0);
    $display("[TB] switch done");
    settle();

    // 6. Reset in the middle of a debounce.
    btn_rst = 1'b1;
    step(4);
    rst_n = 1'b0;
    step(1); chk("midrst.clear", clear, 1'b0);
    step(1); chk("midrst.clear", clear, 1'b0);
    rst_n = 1'b1;
    step(5); chk("midrst.e5.clear", clear, 1'b0);
    step(1); chk("midrst.e6.clear", clear, 1'b1);
    step(1); chk("midrst.e7.clear", clear, 1'b0);
    $display("[TB] mid-debounce reset done");
    settle();

    // Randomized bouncy inputs with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) btn_pause = ~btn_pause;
      if ($urandom_range(0, 6) == 0) btn_rst = ~btn_rst;
      if ($urandom_range(0, 9) == 0) sw_adj = ~sw_adj;
      if ($urandom_range(0, 9) == 0) sw_sel = ~sw_sel;
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 400) == 0) rst_n = 1'b0;
      step(1);
    end
    $display("[TB] random phase done");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
